// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by the RX path, the TX path and the baud
//   generator: receiver state encoding, character width and the default
//   oversampling ratio.
// ----------------------------------------------------------------------------
package uart_pkg;

    // PARITY is only entered when the receiver is built with
    // UART_RX_PARITY_EN; the encoding is kept stable either way.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int UART_DATA_BITS   = 8;

    // Oversample ticks per bit; the baud generator emits baud_tick at
    // UART_OVS_DEFAULT x baud.
    localparam int UART_OVS_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo_if
//   Valid/ready read port of the UART receive FIFO.
//     rx_data  : byte at the FIFO head
//     rx_valid : FIFO non-empty
//     rx_ready : consumer takes the head when high together with rx_valid
//   master = receiver side (drives data/valid), slave = consumer side.
// ----------------------------------------------------------------------------
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock DEPTH x W FIFO shared by the UART RX and TX paths.
//   Ports:
//     clk, Rst   : clock, asynchronous active-high reset
//     push_i     : write din_i (ignored when full unless popping same cycle)
//     din_i      : write data
//     pop_i      : advance the head (ignored when empty)
//     dout_o     : head entry, straight from storage flops
//     full_o     : level == DEPTH
//     empty_o    : level == 0
//     level_o    : occupancy, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = UART_DATA_BITS,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          wr_en, rd_en;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop_i && !empty_o;
        // At full a write is only accepted if the head frees a slot on the
        // same edge; the write then lands in the slot being vacated.
        wr_en    = push_i && (!full_o || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   16x-oversampled 8N1 UART receiver with a small receive FIFO, feeding the
//   MMIO UART data/status registers.
//   Ports:
//     clk        : system clock
//     Rst        : asynchronous active-high reset
//     baud_tick  : one-clk pulse at OVS x baud; the FSM only moves on ticks
//     rx         : asynchronous serial input, idle high
//     rx_if      : valid/ready read port (rx_data, rx_valid, rx_ready)
//     frame_err  : one-clk pulse, stop bit sampled low (byte discarded)
//     overrun    : one-clk pulse, byte completed while FIFO full (dropped)
//     busy       : receiver FSM not in IDLE
//     level      : FIFO occupancy
//     parity_err : (UART_RX_PARITY_EN only) one-clk pulse with the push of a
//                  byte whose parity bit mismatched
//   Build option: define UART_RX_PARITY_EN to add a parity bit between the
//   data and stop bits (ODD_PARITY selects odd parity).
// ----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int OVS         = UART_OVS_DEFAULT,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit ODD_PARITY  = 1'b0
`endif
) (
    input  logic                   clk,
    input  logic                   Rst,
    input  logic                   baud_tick,
    input  logic                   rx,
    uart_rx_fifo_if.master         rx_if,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int CW = $clog2(OVS);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS/2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------- FSM
    rx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q,   cnt_d;
    logic [2:0]                bit_q,   bit_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    // Set after a bad stop bit: IDLE ignores rx_s until the line goes high
    // again, so a held break yields one frame error rather than a stream.
    logic                      wait_hi_q, wait_hi_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q,   overrun_d;
    logic                      push;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q,    par_bad_d;
    logic                      parity_err_q, parity_err_d;
`endif

    // ---------------------------------------------------------------- FIFO
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full, fifo_empty;
    logic [LW-1:0]             fifo_level;
    logic                      pop;

    assign pop = !fifo_empty && rx_if.rx_ready;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .Rst     (Rst),
        .push_i  (push),
        .din_i   (shreg_q),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        wait_hi_d   = wait_hi_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
`endif
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (wait_hi_q) begin
                        if (rx_s) wait_hi_d = 1'b0;
                    end else if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            cnt_d   = '0;
                            bit_d   = '0;
                        end else begin
                            // Line came back high before mid-bit: a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        par_bad_d = ((^shreg_q) ^ rx_s) != ODD_PARITY;
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = IDLE;
`endif
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (rx_s) begin
                            push = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            wait_hi_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // A push at full is dropped by the FIFO unless the head pops too.
        overrun_d = push && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
        parity_err_d = push && par_bad_q;
`endif
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            sync_q      <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            wait_hi_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            wait_hi_q   <= wait_hi_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.rx_data  = fifo_dout;
    assign rx_if.rx_valid = !fifo_empty;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != IDLE);
    assign level          = fifo_level;
`ifdef UART_RX_PARITY_EN
    assign parity_err     = parity_err_q;
`endif

endmodule
